// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file constants and the register address type used by decode
package mips_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int REG_ZERO = 0;
  typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/popcount_delta.sv
// popcount_delta: +1/-1/0 pending-count adjustment from old scoreboard bits at the issue (iss_*) and write (wr_*) addresses
module popcount_delta (
  input  logic iss_v,
  input  logic wr_v,
  input  logic same,
  input  logic iss_old,
  input  logic wr_old,
  output logic inc,
  output logic dec
);
  always_comb begin
    inc = iss_v & ~iss_old;
    dec = wr_v & wr_old & ~(iss_v & same);
  end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file (NRD comb read ports rd_*, write port wr_*, bypass, zero reg) with pending scoreboard (iss_*, rd_pending, pend_cnt)
module reg_file_sb
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_pending,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [AW:0]      pend_cnt
);
  localparam int N = 1 << AW;
  logic [DW-1:0] regs_q [N];
  logic [N-1:0] pend_q, pend_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr_ok, iss_ok, inc, dec;
  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == AW'(REG_ZERO));
  assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == AW'(REG_ZERO));
  popcount_delta u_delta (
    .iss_v(iss_ok),
    .wr_v(wr_ok),
    .same(iss_addr == wr_addr),
    .iss_old(pend_q[iss_addr]),
    .wr_old(pend_q[wr_addr]),
    .inc(inc),
    .dec(dec)
  );
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) pend_d[wr_addr] = 1'b0;
    if (iss_ok) pend_d[iss_addr] = 1'b1;
    cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok) regs_q[wr_addr] <= wr_data;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
  end
  assign pend_cnt = cnt_q;
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    assign a = rd_addr[g*AW +: AW];
    assign hit = wr_en && wr_addr == a;
    assign rd_data[g*DW +: DW] = (rst || (ZERO_REG != 0 && a == AW'(REG_ZERO))) ? '0 :
                                 hit ? wr_data : regs_q[a];
    assign rd_pending[g] = !rst && pend_q[a] && !hit;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: randomized and directed checks of reg_file_sb against a behavioural model
module tb_reg_file_sb;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [9:0] a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic [1:0] a_rd_pending;
  logic a_wr_en = 0, a_iss_en = 0;
  logic [4:0] a_wr_addr = '0, a_iss_addr = '0;
  logic [31:0] a_wr_data = '0;
  logic [5:0] a_pend_cnt;
  logic [8:0] b_rd_addr = '0;
  logic [47:0] b_rd_data;
  logic [2:0] b_rd_pending;
  logic b_wr_en = 0, b_iss_en = 0;
  logic [2:0] b_wr_addr = '0, b_iss_addr = '0;
  logic [15:0] b_wr_data = '0;
  logic [3:0] b_pend_cnt;
  int checks = 0, failures = 0;
  reg_file_sb u_a (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_pending(a_rd_pending),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_addr(a_iss_addr), .pend_cnt(a_pend_cnt)
  );
  reg_file_sb #(.DW(16), .AW(3), .NRD(3), .ZERO_REG(1)) u_b (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_pending(b_rd_pending),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr), .pend_cnt(b_pend_cnt)
  );
  logic [31:0] mem [32];
  bit pend [32];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = '0;
        pend[i] = 0;
      end
    end else begin
      if (a_wr_en && a_wr_addr != 0) begin
        mem[a_wr_addr] = a_wr_data;
        pend[a_wr_addr] = 0;
      end
      if (a_iss_en && a_iss_addr != 0) pend[a_iss_addr] = 1;
    end
  end
  always @(negedge clk) begin
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(pend[i]);
    if (rst) n = 0;
    checks++;
    if (int'(a_pend_cnt) != n) begin
      failures++;
      $display("FAIL model_pend_cnt t=%0t got=%0d exp=%0d", $time, a_pend_cnt, n);
    end
    for (int p = 0; p < 2; p++) begin
      logic [4:0] ad;
      logic [31:0] ed;
      logic ep;
      bit byp;
      ad = a_rd_addr[p*5 +: 5];
      byp = a_wr_en && a_wr_addr == ad;
      ed = (rst || ad == 0) ? 32'h0 : byp ? a_wr_data : mem[ad];
      ep = !rst && pend[ad] && !byp;
      checks++;
      if (a_rd_data[p*32 +: 32] !== ed || a_rd_pending[p] !== ep) begin
        failures++;
        $display("FAIL model_port%0d t=%0t addr=%0d got=%h/%b exp=%h/%b", p, $time, ad,
                 a_rd_data[p*32 +: 32], a_rd_pending[p], ed, ep);
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_a();
    a_wr_en = 0;
    a_iss_en = 0;
  endtask
  initial begin
    repeat (3) step();
    chk("reset_cnt", 64'(a_pend_cnt), 0);
    rst = 0;
    a_wr_en = 1; a_wr_addr = 8; a_wr_data = 32'hF; a_rd_addr = {5'd8, 5'd0};
    @(negedge clk);
    chk("bypass_r8", 64'(a_rd_data[63:32]), 64'hF);
    step(); idle_a();
    @(negedge clk);
    chk("stored_r8", 64'(a_rd_data[63:32]), 64'hF);
    step();
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 32'hDEADBEEF; a_rd_addr = {5'd8, 5'd0};
    @(negedge clk);
    chk("r0_write_read", 64'(a_rd_data[31:0]), 0);
    step(); idle_a();
    a_iss_en = 1; a_iss_addr = 0;
    step(); idle_a();
    @(negedge clk);
    chk("r0_pending", 64'(a_rd_pending[0]), 0);
    chk("r0_cnt", 64'(a_pend_cnt), 0);
    step();
    a_iss_en = 1; a_iss_addr = 3;
    step(); idle_a(); a_rd_addr = {5'd0, 5'd3};
    @(negedge clk);
    chk("r3_pending", 64'(a_rd_pending[0]), 1);
    chk("r3_cnt", 64'(a_pend_cnt), 1);
    step();
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'h7;
    @(negedge clk);
    chk("r3_commit_pending", 64'(a_rd_pending[0]), 0);
    chk("r3_commit_data", 64'(a_rd_data[31:0]), 64'h7);
    step(); idle_a();
    @(negedge clk);
    chk("r3_cnt_after", 64'(a_pend_cnt), 0);
    step();
    a_iss_en = 1; a_iss_addr = 5; a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'h11;
    step(); idle_a(); a_rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("r5_data", 64'(a_rd_data[31:0]), 64'h11);
    chk("r5_pending", 64'(a_rd_pending[0]), 1);
    chk("r5_cnt", 64'(a_pend_cnt), 1);
    for (int c = 0; c < 3000; c++) begin
      step();
      a_wr_en = ($urandom_range(0, 1) == 1);
      a_iss_en = ($urandom_range(0, 9) < 4);
      a_wr_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a_iss_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a_wr_data = $urandom;
      for (int p = 0; p < 2; p++) begin
        int s;
        s = $urandom_range(0, 2);
        a_rd_addr[p*5 +: 5] = s == 0 ? a_wr_addr : s == 1 ? a_iss_addr : 5'($urandom);
      end
    end
    step(); idle_a();
    for (int i = 1; i < 8; i++) begin
      a_iss_en = 1; a_iss_addr = 5'(i);
      step();
    end
    idle_a();
    rst = 1;
    @(negedge clk);
    chk("rst_live_cnt", 64'(a_pend_cnt), 0);
    step(); step();
    rst = 0;
    for (int k = 0; k < 16; k++) begin
      a_rd_addr = {5'(2*k+1), 5'(2*k)};
      @(negedge clk);
      chk("post_rst_regs", {a_rd_data}, 0);
      chk("post_rst_pend", 64'({a_pend_cnt, a_rd_pending}), 0);
      step();
    end
    b_wr_en = 1; b_wr_addr = 7; b_wr_data = 16'hA5A5;
    step();
    b_wr_addr = 1; b_wr_data = 16'h0001;
    step();
    b_wr_addr = 2; b_wr_data = 16'h0002;
    step();
    b_wr_en = 0; b_rd_addr = {3'd2, 3'd1, 3'd7};
    @(negedge clk);
    chk("b_ports", 64'(b_rd_data), 64'h0002_0001_A5A5);
    for (int i = 1; i < 8; i++) begin
      step();
      b_iss_en = 1; b_iss_addr = 3'(i);
    end
    step(); b_iss_en = 0;
    @(negedge clk);
    chk("b_cnt7", 64'(b_pend_cnt), 7);
    chk("b_pending", 64'(b_rd_pending), 64'b111);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
